// File: rtl/display_update_arbiter.sv
// Shares the 7-segment serializer among the time, blink and periodic refresh update sources.
// Latches and coalesces requests, grants by fixed priority, settles, starts, and waits out busy with a timeout.
module display_update_arbiter #(
   parameter int unsigned SYS_CLK_HZ   = 5_000_000,
   parameter int unsigned REFRESH_HZ   = 4,
   parameter int unsigned START_DELAY  = 4,
   parameter int unsigned BUSY_TIMEOUT = 1023
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic       i_time_req,
   input  logic       i_blink_req,
   input  logic       i_busy,
   output logic       o_start_stb,
   output logic [1:0] o_grant_src,
   output logic       o_active,
   output logic       o_done_stb,
   output logic       o_timeout_err
);

   localparam int unsigned DIV   = SYS_CLK_HZ / REFRESH_HZ;
   localparam int unsigned REF_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DLY_W = $clog2(START_DELAY + 1);
   localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_BUSY   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             p_time_q, p_time_d;
   logic             p_blink_q, p_blink_d;
   logic             p_ref_q, p_ref_d;
   logic [REF_W-1:0] ref_q, ref_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [1:0]       src_q, src_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             grant_c;
   logic             ref_fire_c;
   logic             to_hit_c;

   // State and counter registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         p_time_q  <= 1'b0;
         p_blink_q <= 1'b0;
         p_ref_q   <= 1'b0;
         ref_q     <= '0;
         dly_q     <= '0;
         to_q      <= '0;
         src_q     <= 2'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_time_q  <= p_time_d;
         p_blink_q <= p_blink_d;
         p_ref_q   <= p_ref_d;
         ref_q     <= ref_d;
         dly_q     <= dly_d;
         to_q      <= to_d;
         src_q     <= src_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state, grant, counters and pending-flag update.
   always_comb begin
      state_d    = state_q;
      p_time_d   = p_time_q;
      p_blink_d  = p_blink_q;
      p_ref_d    = p_ref_q;
      ref_d      = ref_q;
      dly_d      = dly_q;
      to_d       = to_q;
      src_d      = src_q;
      done_d     = 1'b0;
      err_d      = err_q;
      grant_c    = 1'b0;
      ref_fire_c = 1'b0;
      to_hit_c   = (to_q >= TO_W'(BUSY_TIMEOUT - 1));

      case (state_q)
         ST_IDLE: begin
            if (i_en && (p_time_q || p_blink_q || p_ref_q)) begin
               grant_c = 1'b1;
               state_d = ST_SETTLE;
               dly_d   = '0;
               if (p_time_q) begin
                  src_d    = 2'd1;
                  p_time_d = 1'b0;
               end else if (p_blink_q) begin
                  src_d     = 2'd2;
                  p_blink_d = 1'b0;
               end else begin
                  src_d   = 2'd3;
                  p_ref_d = 1'b0;
               end
            end
         end
         ST_SETTLE: begin
            if (dly_q >= DLY_W'(START_DELAY - 1)) state_d = ST_START;
            else dly_d = dly_q + DLY_W'(1);
         end
         ST_START: begin
            to_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (to_q != TO_W'(BUSY_TIMEOUT)) to_d = to_q + TO_W'(1);
            if (i_busy) begin
               state_d = ST_BUSY;
            end else if (to_hit_c) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (to_q != TO_W'(BUSY_TIMEOUT)) to_d = to_q + TO_W'(1);
            if (!i_busy) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (to_hit_c) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Refresh phase restarts on any grant and only advances while idle.
      if (grant_c) begin
         ref_d = '0;
      end else if (i_en && (state_q == ST_IDLE)) begin
         if (ref_q >= REF_W'(DIV - 1)) begin
            ref_d      = '0;
            ref_fire_c = 1'b1;
         end else begin
            ref_d = ref_q + REF_W'(1);
         end
      end

      if (i_time_req)  p_time_d  = 1'b1;
      if (i_blink_req) p_blink_d = 1'b1;
      if (ref_fire_c)  p_ref_d   = 1'b1;
   end

   assign o_start_stb   = (state_q == ST_START);
   assign o_active      = (state_q != ST_IDLE);
   assign o_grant_src   = src_q;
   assign o_done_stb    = done_q;
   assign o_timeout_err = err_q;

endmodule

// File: tb/tb_display_update_arbiter.sv
// Directed bench for display_update_arbiter: one instance for sequencing/timeout, one fast-refresh instance.
module tb_display_update_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, time_req, blink_req, busy;
   logic       start, active, done, err;
   logic [1:0] src;
   logic       r_en, r_time_req, r_busy;
   logic       r_start, r_active, r_done, r_err;
   logic [1:0] r_src;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   display_update_arbiter #(.BUSY_TIMEOUT(20)) u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_time_req(time_req),
      .i_blink_req(blink_req), .i_busy(busy), .o_start_stb(start),
      .o_grant_src(src), .o_active(active), .o_done_stb(done), .o_timeout_err(err)
   );

   display_update_arbiter #(.SYS_CLK_HZ(1000), .REFRESH_HZ(10), .START_DELAY(4), .BUSY_TIMEOUT(20)) u_ref (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(r_en), .i_time_req(r_time_req),
      .i_blink_req(1'b0), .i_busy(r_busy), .o_start_stb(r_start),
      .o_grant_src(r_src), .o_active(r_active), .o_done_stb(r_done), .o_timeout_err(r_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nst;
      int ls;
      rst_n = 1'b0; en = 1'b1; time_req = 1'b0; blink_req = 1'b0; busy = 1'b0;
      r_en = 1'b0; r_time_req = 1'b0; r_busy = 1'b0;
      step(); step();
      chk("rst_start", start, 0);
      chk("rst_src", src, 0);
      chk("rst_active", active, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;

      // Single time request.
      for (int o = 0; o <= 22; o++) begin
         step();
         time_req = (o == 0);
         busy     = (o >= 7 && o <= 16);
         chk("t1_start", start, (o == 6));
         chk("t1_active", active, (o >= 2 && o <= 17));
         chk("t1_done", done, (o == 18));
         chk("t1_src", src, (o >= 2) ? 1 : 0);
      end

      // Simultaneous time+blink, extra blinks during busy coalesce.
      nst = 0;
      for (int o = 0; o <= 44; o++) begin
         step();
         time_req  = (o == 0);
         blink_req = (o == 0 || o == 10 || o == 12);
         busy      = (o >= 7 && o <= 16) || (o >= 24 && o <= 33);
         if (start) nst++;
         chk("t2_start", start, (o == 6 || o == 23));
         chk("t2_done", done, (o == 18 || o == 35));
         if (o == 6)  chk("t2_src_time", src, 1);
         if (o == 23) chk("t2_src_blink", src, 2);
      end
      chk("t2_nstart", nst, 2);

      // Busy never asserted: timeout, then a normal request with sticky error.
      for (int o = 0; o <= 45; o++) begin
         step();
         time_req = (o == 0 || o == 30);
         busy     = (o >= 37 && o <= 40);
         chk("t3_start", start, (o == 6 || o == 36));
         chk("t3_active", active, (o >= 2 && o <= 26) || (o >= 32 && o <= 41));
         chk("t3_done", done, (o == 42));
         chk("t3_err", err, (o >= 27));
      end

      // Enable gating, and enable dropping mid-sequence.
      for (int o = 0; o <= 25; o++) begin
         step();
         time_req = (o == 0);
         en       = (o >= 10 && o < 12);
         busy     = (o >= 16 && o <= 18);
         chk("t4_start", start, (o == 15));
         chk("t4_active", active, (o >= 11 && o <= 19));
         chk("t4_done", done, (o == 20));
      end
      en = 1'b1;

      // Reset during busy clears outputs and pending flags.
      for (int o = 0; o <= 40; o++) begin
         step();
         time_req  = (o == 0 || o == 31);
         blink_req = (o == 9);
         busy      = (o >= 7 && o <= 10);
         if (o == 10) begin
            chk("t5_busy_active", active, 1);
            rst_n = 1'b0;
            #1;
            chk("t5_rst_start", start, 0);
            chk("t5_rst_src", src, 0);
            chk("t5_rst_active", active, 0);
            chk("t5_rst_done", done, 0);
            chk("t5_rst_err", err, 0);
         end else begin
            if (o == 11) rst_n = 1'b1;
            chk("t5_start", start, (o == 6 || o == 37));
            if (o > 10) chk("t5_active", active, (o >= 33));
         end
      end

      // Refresh timer frozen while disabled.
      nst = 0;
      for (int o = 0; o < 150; o++) begin
         step();
         if (r_start || r_active) nst++;
      end
      chk("r_frozen", nst, 0);

      // Periodic refresh with a time request resetting the phase.
      ls = -100;
      for (int o = 0; o <= 390; o++) begin
         step();
         r_en       = 1'b1;
         r_time_req = (o == 260);
         r_busy     = (o - ls >= 1) && (o - ls <= 3);
         if (r_start) ls = o;
         chk("r_start", r_start, (o == 105 || o == 215 || o == 266 || o == 376));
         if (o == 105 || o == 215 || o == 376) chk("r_src_ref", r_src, 3);
         if (o == 266) chk("r_src_time", r_src, 1);
         if (o == 110 || o == 220) chk("r_done", r_done, 1);
      end
      chk("r_err", r_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/display_update_arbiter.md
# display_update_arbiter

Schedules and shares the 7-segment serializer (output_wrapper) among three update sources: the clock-register update strobe, the colon-blink toggle, and an internal periodic refresh timer. It latches and coalesces requests, grants one at a time by fixed priority, inserts a settle delay so the BCD path is stable, issues the serializer start strobe, and tracks the serializer busy handshake with a timeout. It sits between basic_clock / clock_stb_gen and output_wrapper in clock_wrapper, replacing the fixed shift-register start delay.

## Interface

Parameters:
- SYS_CLK_HZ, 5_000_000, system clock frequency.
- REFRESH_HZ, 4, periodic refresh rate; divider DIV = SYS_CLK_HZ/REFRESH_HZ.
- START_DELAY, 4, settle cycles between grant and start strobe (≥1).
- BUSY_TIMEOUT, 1023, maximum cycles spent in WAIT_ACK+BUSY before abort.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  reset: asynchronous, active-low.
- i_en  input  1  enable; low blocks new grants and holds the refresh timer.
- i_time_req  input  1  one-cycle strobe, time register changed.
- i_blink_req  input  1  one-cycle strobe, colon state changed.
- i_busy  input  1  serializer busy.
- o_start_stb  output  1  one-cycle serializer start.
- o_grant_src  output  2  source of current/last grant: 0 none, 1 time, 2 blink, 3 refresh.
- o_active  output  1  high outside IDLE.
- o_done_stb  output  1  one-cycle pulse on normal completion.
- o_timeout_err  output  1  sticky; set on busy timeout.

## Operation

- Pending flags p_time, p_blink, p_ref: set by their strobe or timer event. A flag is cleared only when its source is granted. Set wins over clear in the same cycle. Repeated strobes while pending coalesce into one update.
- Refresh timer: counts 0..DIV-1 while i_en is high. On reaching DIV-1 it sets p_ref and wraps to 0. It reloads to 0 on every grant, so refresh only fires after DIV idle cycles with no other update.
- Priority at grant: time > blink > refresh.
- FSM:
  - IDLE: if i_en and any pending flag is set, grant the highest-priority source. On grant, latch o_grant_src, clear that flag, clear the delay counter, and go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: stay for START_DELAY cycles, then go to START.
  - START: o_start_stb = 1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK: go to BUSY when i_busy = 1.
  - BUSY: go to IDLE when i_busy = 0, pulsing o_done_stb in the transition cycle.
  - Timeout: WAIT_ACK and BUSY increment the timeout counter each cycle. When the counter reaches BUSY_TIMEOUT, set o_timeout_err and go to IDLE with no o_done_stb. Only reset clears o_timeout_err.
- i_en falling mid-sequence: the sequence in progress completes normally. Pending flags are still captured while i_en is low.
- Requests that arrive during SETTLE through BUSY stay pending and are served on the next IDLE visit. Back-to-back service is allowed, with one IDLE cycle minimum.
- Counter widths: $clog2(DIV), $clog2(START_DELAY+1), $clog2(BUSY_TIMEOUT+1). All counters saturate and never wrap mid-state.

## Timing

- Reset (asynchronous assert, synchronous release): state IDLE, all flags and counters 0.
  - Outputs during reset: o_start_stb = 0, o_grant_src = 0, o_active = 0, o_done_stb = 0, o_timeout_err = 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Request latency: a strobe in cycle N sets the flag at the end of N. IDLE grants in N+1, and SETTLE occupies N+2 .. N+1+START_DELAY.
  - o_start_stb is asserted in cycle N+2+START_DELAY, which is N+6 at the default.
- o_active is high from the cycle after the grant through the last BUSY cycle.
- If i_busy is already high during START, the block goes WAIT_ACK→BUSY on the next cycle.
- A reset asserted mid-sequence aborts immediately. A start strobe is never reissued automatically.

## Test plan

- Single time request: i_time_req pulsed at cycle 10, i_busy high for cycles 17–40 -> o_start_stb only at cycle 16, o_grant_src = 1, o_done_stb at cycle 41, o_active high 12–40.
- Priority and coalescing: i_blink_req and i_time_req in the same cycle, then two more i_blink_req during BUSY -> time served first, then exactly one blink transfer; exactly two o_start_stb pulses in total.
- Refresh: SYS_CLK_HZ=1000, REFRESH_HZ=10, no requests -> o_start_stb with o_grant_src = 3 every 100 + sequence-length cycles; an i_time_req mid-period resets the refresh phase.
- Timeout: BUSY_TIMEOUT=20, i_busy held low after start -> o_timeout_err set 20 cycles after START, no o_done_stb, return to IDLE, next request still serviced and o_timeout_err stays 1.
- Enable: i_en low while i_time_req is pulsed -> no o_start_stb and the timer is frozen; i_en raised -> start strobe START_DELAY+1 cycles later.
- Reset during BUSY: i_reset_n low for 1 cycle -> all outputs 0 immediately and pending flags cleared; no start strobe until a new request arrives.
